// File: rtl/out_pkg.sv
// Shared constants, state type and modulo helper for the output transfer sequencer.
package out_pkg;

  localparam int LANES  = 24;
  localparam int LANE_W = 6;
  localparam int LEN_W  = 16;
  localparam int BEAT_W = LANES * 64;  // 1536-bit datapath beat

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // One restoring step: remove 24*2^k from v when it fits.
  function automatic logic [LEN_W-1:0] mod_step(input logic [LEN_W-1:0] v,
                                                input logic [3:0]       k);
    logic [LEN_W-1:0] d;
    d = LEN_W'(LANES) << k;
    return (v >= d) ? (v - d) : v;
  endfunction

endpackage

// File: rtl/out_seq_ctrl_lane_mod24.sv
// Sequential restoring modulo-24 unit: 12 fixed iterations (k = 11..0).
// The first iteration is applied on the start edge, so busy is high for
// 11 cycles and the result is valid on the 12th cycle after start.
module lane_mod24
  import out_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  value,
  output logic              busy,
  output logic [LANE_W-1:0] result
);

  logic [LEN_W-1:0] val_q;
  logic [3:0]       k_q;
  logic             busy_q;
  logic [LEN_W-1:0] cur_v;
  logic [3:0]       cur_k;
  logic [LEN_W-1:0] nxt_v;

  // Select the operand for this cycle's subtraction step.
  always_comb begin
    cur_v = start ? value : val_q;
    cur_k = start ? 4'd11 : k_q;
    nxt_v = mod_step(cur_v, cur_k);
  end

  // Iterate one power of two per cycle until k reaches zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      val_q  <= '0;
      k_q    <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      val_q  <= nxt_v;
      k_q    <= 4'd10;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      val_q <= nxt_v;
      if (k_q == 4'd0) busy_q <= 1'b0;
      else             k_q    <= k_q - 4'd1;
    end
  end

  assign busy   = busy_q;
  assign result = val_q[LANE_W-1:0];

endmodule

// File: rtl/out_seq_ctrl.sv
// Transfer sequencer for the 24-lane output realignment stage: accepts one
// descriptor, configures first/last lanes, gates input beats and counts
// output beats to signal completion.
module out_seq_ctrl
  import out_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LANE_W-1:0] cmd_offset,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              in_fire,
  input  logic              out_fire,
  output logic              in_enable,
  output logic              in_tlast,
  output logic [LANE_W-1:0] cfg_first,
  output logic [LANE_W-1:0] cfg_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e            state_q;
  logic [LEN_W:0]    rem_in_q;
  logic [LEN_W-1:0]  rem_out_q;
  logic              cmd_ready_q;
  logic              in_enable_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [LANE_W-1:0] cfg_first_q;
  logic [LANE_W-1:0] cfg_last_q;

  logic              cmd_bad;
  logic              cmd_take;
  logic [LEN_W-1:0]  len_m1;
  logic              tlast_w;
  logic              in_beat;
  logic              out_beat;
  logic              in_last;
  logic              out_last;
  logic              mod_busy;
  logic [LANE_W-1:0] mod_result;

  // Descriptor qualification and beat decode.
  always_comb begin
    cmd_bad  = (cmd_len == '0) || (cmd_offset > LANE_W'(LANES - 1));
    cmd_take = (state_q == IDLE) && cmd_valid && !cmd_bad;
    len_m1   = cmd_len - LEN_W'(1);
    tlast_w  = (state_q == RUN) && (rem_in_q <= (LEN_W+1)'(LANES));
    in_beat  = (state_q == RUN) && in_fire;
    out_beat = ((state_q == RUN) || (state_q == DRAIN)) && out_fire;
    in_last  = in_beat && tlast_w;
    out_last = out_beat && (rem_out_q <= LEN_W'(LANES));
  end

  lane_mod24 u_mod (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (cmd_take),
    .value  (len_m1),
    .busy   (mod_busy),
    .result (mod_result)
  );

  // Sequencer FSM with its remainder counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rem_in_q    <= '0;
      rem_out_q   <= '0;
      cmd_ready_q <= 1'b0;
      in_enable_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cfg_first_q <= '0;
      cfg_last_q  <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid) begin
            if (cmd_bad) begin
              err_q <= 1'b1;
            end else begin
              state_q     <= CALC;
              cmd_ready_q <= 1'b0;
              busy_q      <= 1'b1;
              cfg_first_q <= cmd_offset;
              rem_in_q    <= {1'b0, cmd_len} + (LEN_W+1)'(cmd_offset);
              rem_out_q   <= cmd_len;
            end
          end
        end
        CALC: begin
          if (!mod_busy) begin
            cfg_last_q  <= mod_result;
            state_q     <= RUN;
            in_enable_q <= 1'b1;
          end
        end
        RUN, DRAIN: begin
          if (in_beat)
            rem_in_q <= in_last ? '0 : rem_in_q - (LEN_W+1)'(LANES);
          if (out_beat)
            rem_out_q <= out_last ? '0 : rem_out_q - LEN_W'(LANES);
          // Final output beat wins over final input beat so a coincident
          // last-in/last-out goes straight back to IDLE.
          if (out_last) begin
            state_q     <= IDLE;
            done_q      <= 1'b1;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            in_enable_q <= 1'b0;
          end else if (in_last) begin
            state_q     <= DRAIN;
            in_enable_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign in_enable = in_enable_q;
  assign in_tlast  = tlast_w;
  assign cfg_first = cfg_first_q;
  assign cfg_last  = cfg_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
